// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter that shares the single-port RAM and its address registers.
// Optional lock expiry is enabled with `define ARB_LOCK_TIMEOUT_EN.
module ram_port_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  output logic [ADDR_SIZE-1:0] req0_rdata,
  output logic                 req0_rvalid,
  input  logic [ADDR_SIZE+1:0] req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  output logic [ADDR_SIZE-1:0] req1_rdata,
  output logic                 req1_rvalid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic [1:0]           grant,
  output logic                 lock_timeout
);

  typedef enum logic [1:0] {IDLE, LOCKED, RD_WAIT} state_t;

  state_t               state, state_n;
  logic                 owner, owner_n;
  logic                 rr_last, rr_last_n;
  logic                 acc, acc_port;
  logic [ADDR_SIZE+1:0] acc_word;
  logic [1:0]           acc_cmd;
  logic                 timeout_hit;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] lock_cnt;

  assign timeout_hit = (state == LOCKED) && (lock_cnt == CW'(LOCK_TIMEOUT));

  // Counts owner-silent LOCKED cycles; any owner accept restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       lock_cnt <= '0;
    else if (state != LOCKED || acc)  lock_cnt <= '0;
    else if (!timeout_hit)            lock_cnt <= lock_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (LOCK_TIMEOUT == 0);
  assign timeout_hit        = 1'b0;
`endif

  assign lock_timeout = timeout_hit;

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rr_last_n = rr_last;
    acc       = 1'b0;
    acc_port  = 1'b0;
    unique case (state)
      IDLE: begin
        // rr_last holds the last winner, so the other port wins a tie.
        if (req0_valid || req1_valid) begin
          acc      = 1'b1;
          acc_port = req0_valid ? (req1_valid ? ~rr_last : 1'b0) : 1'b1;
        end
      end
      LOCKED: begin
        if (timeout_hit) begin
          state_n   = IDLE;
          rr_last_n = owner;
        end else begin
          acc      = owner ? req1_valid : req0_valid;
          acc_port = owner;
        end
      end
      RD_WAIT: begin
        if (ram_tx_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    acc_word = acc_port ? req1_data : req0_data;
    acc_cmd  = acc_word[ADDR_SIZE+1:ADDR_SIZE];
    if (acc) begin
      rr_last_n = acc_port;
      owner_n   = acc_port;
      unique case (acc_cmd)
        2'b00, 2'b10: state_n = LOCKED;
        2'b01:        state_n = IDLE;
        default:      state_n = RD_WAIT;
      endcase
    end

    req0_ready = rst_n && acc && !acc_port;
    req1_ready = rst_n && acc &&  acc_port;
  end

  always_comb begin
    grant = 2'b00;
    if (state != IDLE) grant = owner ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      rr_last      <= 1'b1;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      req0_rdata   <= '0;
      req0_rvalid  <= 1'b0;
      req1_rdata   <= '0;
      req1_rvalid  <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      rr_last      <= rr_last_n;
      ram_rx_valid <= acc;
      req0_rvalid  <= 1'b0;
      req1_rvalid  <= 1'b0;
      if (acc) ram_din <= acc_word;
      if (state == RD_WAIT && ram_tx_valid) begin
        if (owner) begin
          req1_rdata  <= ram_dout;
          req1_rvalid <= 1'b1;
        end else begin
          req0_rdata  <= ram_dout;
          req0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the ownership rules.
module tb_ram_port_arbiter;
  localparam int AS = 8;
  localparam int W  = AS + 2;
  localparam int LT = 16;
`ifdef ARB_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req0_data = '0, req1_data = '0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AS-1:0] req0_rdata, req1_rdata;
  logic          req0_rvalid, req1_rvalid;
  logic [W-1:0]  ram_din;
  logic          ram_rx_valid;
  logic [AS-1:0] ram_dout = '0;
  logic          ram_tx_valid = 1'b0;
  logic [1:0]    grant;
  logic          lock_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.ADDR_SIZE(AS), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .grant(grant), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one word on a port until accepted (bounded); returns just after the accept edge.
  task automatic send(input int p, input logic [W-1:0] w, output bit ok);
    ok = 1'b0;
    if (p == 0) begin req0_data = w; req0_valid = 1'b1; end
    else        begin req1_data = w; req1_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*AS+9:0] outs;
    #2;
    outs = {req0_ready, req1_ready, req0_rdata, req1_rdata, req0_rvalid, req1_rvalid,
            ram_din, ram_rx_valid, grant, lock_timeout};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    #10; rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({grant, ram_rx_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release: got %b expected 000", {grant, ram_rx_valid});
    end
  endtask

  task automatic test_lock_read();
    bit ok;
    logic [W-1:0] words [4];
    logic [1:0]   gexp  [4];
    words = '{10'h005, 10'h1A5, 10'h205, 10'h300};
    gexp  = '{2'b01, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      send(0, words[i], ok);
      n_tests++;
      if (!ok || {ram_rx_valid, ram_din} !== {1'b1, words[i]}) begin
        n_fail++; $display("FAIL lock_read_fwd%0d: got ok=%0d rx=%b din=%h expected rx=1 din=%h",
                           i, ok, ram_rx_valid, ram_din, words[i]);
      end
      n_tests++;
      if (grant !== gexp[i]) begin
        n_fail++; $display("FAIL lock_read_grant%0d: got %b expected %b", i, grant, gexp[i]);
      end
    end
    ram_dout = 8'hA5; ram_tx_valid = 1'b1;
    @(posedge clk); #1; ram_tx_valid = 1'b0;
    n_tests++;
    if ({ram_rx_valid, req0_rvalid, req0_rdata, req1_rvalid, grant} !== {1'b0, 1'b1, 8'hA5, 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL lock_read_resp: got rx=%b rv0=%b rd0=%h rv1=%b grant=%b expected 0 1 a5 0 00",
                         ram_rx_valid, req0_rvalid, req0_rdata, req1_rvalid, grant);
    end
    @(posedge clk); #1;
    n_tests++;
    if (req0_rvalid !== 1'b0) begin n_fail++; $display("FAIL lock_read_pulse: got %b expected 0", req0_rvalid); end
  endtask

  task automatic test_lock_stall();
    bit ok, stalled;
    send(0, 10'h010, ok);
    n_tests++;
    if (!ok || ram_din !== 10'h010) begin n_fail++; $display("FAIL stall_lock: got ok=%0d din=%h expected 010", ok, ram_din); end
    req1_data = 10'h020; req1_valid = 1'b1;
    stalled = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (req1_ready || req0_ready) stalled = 1'b0;
    end
    n_tests++;
    if (stalled !== 1'b1) begin n_fail++; $display("FAIL stall_nonowner: got ready seen expected ready 0"); end
    @(posedge clk); #1;
    send(0, 10'h1FF, ok);
    n_tests++;
    if (!ok || {ram_din, grant} !== {10'h1FF, 2'b00}) begin
      n_fail++; $display("FAIL stall_release: got ok=%0d din=%h grant=%b expected 1ff 00", ok, ram_din, grant);
    end
    @(negedge clk);
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL stall_next_ready: got %b expected 10", {req1_ready, req0_ready});
    end
    @(posedge clk); #1; req1_valid = 1'b0;
    n_tests++;
    if ({ram_rx_valid, ram_din, grant} !== {1'b1, 10'h020, 2'b10}) begin
      n_fail++; $display("FAIL stall_port1_fwd: got rx=%b din=%h grant=%b expected 1 020 10", ram_rx_valid, ram_din, grant);
    end
    send(1, 10'h1EE, ok);
    n_tests++;
    if (!ok || grant !== 2'b00) begin n_fail++; $display("FAIL stall_unlock: got ok=%0d grant=%b expected 00", ok, grant); end
  endtask

  task automatic test_round_robin();
    int exp;
    req0_data = 10'h111; req1_data = 10'h1BB;
    req0_valid = 1'b1;   req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = i % 2;
      @(negedge clk);
      n_tests++;
      if ({req1_ready, req0_ready} !== ((exp == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_ready%0d: got %b expected port %0d", i, {req1_ready, req0_ready}, exp);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({ram_din, grant} !== {((exp == 1) ? 10'h1BB : 10'h111), 2'b00}) begin
        n_fail++; $display("FAIL rr_fwd%0d: got din=%h grant=%b expected port %0d grant 00", i, ram_din, grant, exp);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_read_port1();
    bit ok;
    send(1, 10'h300, ok);
    n_tests++;
    if (!ok || {ram_din, grant} !== {10'h300, 2'b10}) begin
      n_fail++; $display("FAIL rd1_issue: got ok=%0d din=%h grant=%b expected 300 10", ok, ram_din, grant);
    end
    req0_data = 10'h155; req0_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rd1_wait_ready: got %b expected 0", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; ram_dout = 8'h3C; ram_tx_valid = 1'b1;
    @(posedge clk); #1; ram_tx_valid = 1'b0;
    n_tests++;
    if ({req1_rvalid, req1_rdata, req0_rvalid, req0_rdata, grant} !== {1'b1, 8'h3C, 1'b0, 8'hA5, 2'b00}) begin
      n_fail++; $display("FAIL rd1_resp: got rv1=%b rd1=%h rv0=%b rd0=%h grant=%b expected 1 3c 0 a5 00",
                         req1_rvalid, req1_rdata, req0_rvalid, req0_rdata, grant);
    end
    @(posedge clk); #1;
    n_tests++;
    if (req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd1_pulse: got %b expected 0", req1_rvalid); end
    ram_dout = 8'h77; ram_tx_valid = 1'b1;
    @(posedge clk); #1; ram_tx_valid = 1'b0;
    n_tests++;
    if ({req0_rvalid, req1_rvalid, req1_rdata} !== {2'b00, 8'h3C}) begin
      n_fail++; $display("FAIL stray_tx: got rv=%b rd1=%h expected 00 3c", {req0_rvalid, req1_rvalid}, req1_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    logic [3*AS+9:0] outs;
    send(0, 10'h300, ok);
    n_tests++;
    if (!ok || grant !== 2'b01) begin n_fail++; $display("FAIL rst_issue: got ok=%0d grant=%b expected 01", ok, grant); end
    #2; rst_n = 1'b0; #1;
    outs = {req0_ready, req1_ready, req0_rdata, req1_rdata, req0_rvalid, req1_rvalid,
            ram_din, ram_rx_valid, grant, lock_timeout};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
    ram_dout = 8'h5A; ram_tx_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
        n_fail++; $display("FAIL rst_no_rvalid%0d: got %b expected 00", i, {req0_rvalid, req1_rvalid});
      end
    end
    ram_tx_valid = 1'b0;
    req0_data = 10'h111; req1_data = 10'h1BB; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_prio: got %b expected 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++;
    if (ram_din !== 10'h111) begin n_fail++; $display("FAIL rst_prio_fwd: got %h expected 111", ram_din); end
  endtask

  task automatic test_lock_hold();
    bit ok, clean;
    send(0, 10'h010, ok);
    n_tests++;
    if (!ok || grant !== 2'b01) begin n_fail++; $display("FAIL hold_lock: got ok=%0d grant=%b expected 01", ok, grant); end
    req1_data = 10'h020; req1_valid = 1'b1;
`ifdef ARB_LOCK_TIMEOUT_EN
    begin
      int at;
      at = 0; clean = 1'b1;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (req1_ready) clean = 1'b0;
        if (lock_timeout) begin at = i; break; end
      end
      n_tests++;
      if (at !== LT + 1 || !clean) begin
        n_fail++; $display("FAIL timeout_cycle: got pulse at %0d clean=%0d expected %0d 1", at, clean, LT + 1);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({grant, lock_timeout} !== 3'b000) begin
        n_fail++; $display("FAIL timeout_release: got grant=%b pulse=%b expected 00 0", grant, lock_timeout);
      end
    end
`else
    clean = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (req1_ready || lock_timeout || grant !== 2'b01) clean = 1'b0;
    end
    n_tests++;
    if (clean !== 1'b1) begin n_fail++; $display("FAIL hold_forever: got lock lost expected held"); end
    @(posedge clk); #1;
    send(0, 10'h1FF, ok);
    n_tests++;
    if (!ok || grant !== 2'b00) begin n_fail++; $display("FAIL hold_release: got ok=%0d grant=%b expected 00", ok, grant); end
`endif
    @(negedge clk);
    n_tests++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_waiter_ready: got %b expected 1", req1_ready); end
    @(posedge clk); #1; req1_valid = 1'b0;
    n_tests++;
    if ({ram_din, grant} !== {10'h020, 2'b10}) begin
      n_fail++; $display("FAIL hold_waiter_fwd: got din=%h grant=%b expected 020 10", ram_din, grant);
    end
    send(1, 10'h1EE, ok);
  endtask

  // Model: mode 0 = no owner, 1 = address held by owner, 2 = owner awaiting read data.
  task automatic test_random();
    int mode, owner, prio, cnt, p;
    logic [W-1:0]  m_din;
    logic [AS-1:0] m_rdata [2];
    bit   [1:0]    m_rv, exp_rdy, pend;
    bit            m_rxv, exp_to;
    logic [1:0]    eg;
    req0_valid = 1'b0; req1_valid = 1'b0; ram_tx_valid = 1'b0;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    mode = 0; owner = 0; prio = 0; cnt = 0;
    m_din = '0; m_rxv = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0; m_rv = '0; pend = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(pend[0] && $urandom_range(0, 3) != 0)) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_data = W'($urandom_range(0, 1023));
      end
      if (!(pend[1] && $urandom_range(0, 3) != 0)) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_data = W'($urandom_range(0, 1023));
      end
      ram_tx_valid = ($urandom_range(0, 3) == 0);
      ram_dout     = AS'($urandom_range(0, 255));
      @(negedge clk);
      n_tests++;
      if ({ram_rx_valid, ram_din} !== {m_rxv, m_din}) begin
        n_fail++; $display("FAIL rand_ram c%0d: got rx=%b din=%h expected rx=%b din=%h", c, ram_rx_valid, ram_din, m_rxv, m_din);
      end
      n_tests++;
      if ({req0_rvalid, req0_rdata, req1_rvalid, req1_rdata} !== {m_rv[0], m_rdata[0], m_rv[1], m_rdata[1]}) begin
        n_fail++; $display("FAIL rand_resp c%0d: got %b %h %b %h expected %b %h %b %h", c, req0_rvalid, req0_rdata,
                           req1_rvalid, req1_rdata, m_rv[0], m_rdata[0], m_rv[1], m_rdata[1]);
      end
      exp_rdy = '0;
      exp_to  = TO_EN && mode == 1 && cnt == LT;
      if (mode == 0) begin
        if (req0_valid && req1_valid) exp_rdy[prio] = 1'b1;
        else if (req0_valid)          exp_rdy[0] = 1'b1;
        else if (req1_valid)          exp_rdy[1] = 1'b1;
      end else if (mode == 1 && !exp_to) begin
        exp_rdy[owner] = (owner == 0) ? req0_valid : req1_valid;
      end
      eg = (mode == 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
      n_tests++;
      if ({req1_ready, req0_ready, grant, lock_timeout} !== {exp_rdy, eg, exp_to}) begin
        n_fail++; $display("FAIL rand_ctl c%0d: got rdy=%b grant=%b to=%b expected rdy=%b grant=%b to=%b",
                           c, {req1_ready, req0_ready}, grant, lock_timeout, exp_rdy, eg, exp_to);
      end
      m_rxv = 1'b0; m_rv = '0;
      pend  = {req1_valid && !exp_rdy[1], req0_valid && !exp_rdy[0]};
      if (exp_rdy != 2'b00) begin
        p = exp_rdy[1] ? 1 : 0;
        m_rxv = 1'b1; m_din = (p == 1) ? req1_data : req0_data;
        prio = 1 - p; owner = p; cnt = 0;
        case (m_din[W-1:AS])
          2'b01:   mode = 0;
          2'b11:   mode = 2;
          default: mode = 1;
        endcase
      end else if (mode == 2 && ram_tx_valid) begin
        m_rdata[owner] = ram_dout; m_rv[owner] = 1'b1; mode = 0;
      end else if (exp_to) begin
        mode = 0; prio = 1 - owner;
      end else if (mode == 1) begin
        cnt++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; ram_tx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_read();
    test_lock_stall();
    test_round_robin();
    test_read_port1();
    test_reset_mid_read();
    test_lock_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
